fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the 16-deep synchronous FIFO between NREQ requesters.
//  Round-robin arbitration with burst locking: a granted requester owns the port for up to
//  BURST accepted words. Drives the FIFO's wr/data_in and obeys fifo_full.
//  A stall timeout releases the port from an owner that stays blocked on fifo_full.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  DW       8   data width; matches FIFO data_in
//  BURST    4   max words accepted per grant (1..16)
//  MAXSTALL 15  consecutive fifo_full cycles tolerated before forced release (>=1)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         reset, asynchronous, active-high
//  req        in   NREQ      per-requester word valid; must hold until ack
//  req_data   in   NREQ*DW   requester i data at [i*DW +: DW]
//  ack        out  NREQ      one-hot; word of requester i is consumed this cycle
//  fifo_full  in   1         from FIFO status
//  fifo_wr    out  1         FIFO write strobe
//  fifo_data  out  DW        FIFO write data
//  owner      out  clog2(NREQ)  current / last owner index
//  busy       out  1         1 while in BURST state
//  stall_err  out  1         one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (async, any state incl. mid-burst): state=IDLE, owner=0, last_owner=NREQ-1,
//   beat_cnt=0, stall_cnt=0, stall_err=0. Outputs ack=0, fifo_wr=0, fifo_data=0, busy=0.
//   A word in flight at reset is not written.
//  FSM states: IDLE, BURST.
//  IDLE: if |req, winner = first set req scanning from (last_owner+1) mod NREQ upward with
//   wrap. Register owner=winner, beat_cnt=0, stall_cnt=0, and go to BURST. Otherwise stay.
//   No ack or fifo_wr is issued in IDLE.
//  BURST (combinational outputs): accept = req[owner] & ~fifo_full.
//   fifo_wr=accept; ack[owner]=accept; fifo_data=req_data[owner] (0 when not busy).
//  BURST transitions, in priority order:
//   a) accept and beat_cnt==BURST-1 -> IDLE, last_owner=owner.
//   b) req[owner]==0 -> IDLE, last_owner=owner. The burst ends early with no penalty.
//   c) fifo_full & req[owner]: stall_cnt++. When stall_cnt==MAXSTALL-1 -> IDLE,
//      last_owner=owner, stall_err=1 on the next cycle.
//   d) accept (not last): beat_cnt++, stall_cnt=0.
//  Latency: req rising in IDLE -> first ack 1 cycle later. Last word of a burst -> next
//   owner's first ack 2 cycles later (one IDLE bubble).
//  Words per grant never exceed BURST, and fifo_wr is never asserted while fifo_full=1,
//   so FIFO overflow cannot be set by this block.
//  beat_cnt width = clog2(BURST)+1 (no wrap). stall_cnt saturates at MAXSTALL-1.
//  owner holds its value in IDLE; it only changes at the IDLE->BURST grant.
//  Simultaneous events: fifo_full with the owner's req low -> rule b.
//   Other requesters toggling req mid-burst has no effect until IDLE.
// STRUCTURE
//  Package fifo_arb_pkg: state encoding localparams (ST_IDLE=0, ST_BURST=1) and a
//   clog2 function used for owner/beat_cnt widths.
//  Sub-module rr_priority_pick (combinational): inputs req and last_owner; outputs
//   winner index and any. The top level holds the FSM, counters and datapath mux.
// TESTING
//  1 Reset, req=4'b0001 held, fifo_full=0, BURST=4 -> owner=0; ack[0] high for 4 cycles,
//    then 1 IDLE cycle, then 4 more; fifo_data tracks req_data[7:0].
//  2 req=4'b1111 constant -> grant order 0,1,2,3,0; each burst is exactly 4 writes;
//    exactly 1 bubble between bursts.
//  3 Owner 2 drops req after 2 words while req[3]=1 -> IDLE next cycle, then owner=3.
//  4 fifo_full=1 for 3 cycles mid-burst -> fifo_wr=0 and ack=0 during the stall;
//    the burst resumes with remaining beats intact; stall_err stays 0.
//  5 fifo_full held 15 cycles with owner 1 requesting -> release to IDLE;
//    stall_err pulses 1 cycle; next grant goes to 2 if req[2]=1.
//  6 Assert rst mid-burst (beat 2) -> ack/fifo_wr/busy drop immediately;
//    after release, req=4'b1001 grants owner 0 first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // busy is high exactly when the FSM is in ST_BURST, so it doubles as the state observation point.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request strictly after last_owner, wrapping, last_owner itself last.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int OW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   last_owner,
  output logic [OW-1:0]   winner,
  output logic            any
);

  logic [OW-1:0] cand;

  // Scan from the farthest offset down so the nearest set request overwrites the others.
  always_comb begin
    winner = '0;
    cand   = '0;
    any    = |req;
    for (int i = NREQ; i >= 1; i--) begin
      cand = OW'((int'(last_owner) + i) % NREQ);
      if (req[cand]) winner = cand;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between NREQ requesters: round-robin grants, BURST-word locking, stall release.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int BURST    = 4,
  parameter int MAXSTALL = 15,
  localparam int OW = clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  input  logic               fifo_full,
  output logic               fifo_wr,
  output logic [DW-1:0]      fifo_data,
  output logic [OW-1:0]      owner,
  output logic               busy,
  output logic               stall_err
);

  localparam int BW = clog2(BURST) + 1;
  localparam int SW = clog2(MAXSTALL) + 1;

  arb_state_e    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_owner_q, last_owner_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          stall_err_q, stall_err_d;

  logic [OW-1:0] winner;
  logic          any_req;
  logic          owner_req;
  logic          accept;
  logic [DW-1:0] lane [NREQ];

  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (winner),
    .any        (any_req)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) lane[i] = req_data[i*DW +: DW];
  end

  // Valid/ready: req[i] is valid and must hold; ack[i] is the ready that consumes the word the same cycle.
  assign owner_req = req[owner_q];
  assign accept    = (state_q == ST_BURST) & owner_req & ~fifo_full;
  assign ack       = accept ? (NREQ'(1) << owner_q) : '0;
  assign fifo_wr   = accept;
  assign fifo_data = (state_q == ST_BURST) ? lane[owner_q] : '0;
  assign owner     = owner_q;
  assign busy      = (state_q == ST_BURST);
  assign stall_err = stall_err_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_d       = beat_q;
    stall_d      = stall_q;
    stall_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_BURST;
          owner_d = winner;
          beat_d  = '0;
          stall_d = '0;
        end
      end
      ST_BURST: begin
        if (accept && (beat_q == BW'(BURST - 1))) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end else if (!owner_req) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
        end else if (fifo_full) begin
          // Owner is still requesting but blocked; give up the port after MAXSTALL blocked cycles.
          if (stall_q == SW'(MAXSTALL - 1)) begin
            state_d      = ST_IDLE;
            last_owner_d = owner_q;
            stall_err_d  = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end else begin
          beat_d  = beat_q + 1'b1;
          stall_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
      beat_q       <= '0;
      stall_q      <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_q       <= beat_d;
      stall_q      <= stall_d;
      stall_err_q  <= stall_err_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with hand-derived per-cycle expectations.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = 32'h44332211;
  logic        fifo_full = 1'b0;
  logic [3:0]  ack;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic [1:0]  owner;
  logic        busy;
  logic        stall_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4), .MAXSTALL(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .owner     (owner),
    .busy      (busy),
    .stall_err (stall_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs already set; checks, then moves to the next negedge.
  task automatic expect_cyc(input string tag, input logic [3:0] e_ack, input logic [7:0] e_data,
                            input logic e_busy, input logic [1:0] e_owner, input logic e_err);
    #1;
    chk({tag, "/ack"},  32'(ack),       32'(e_ack));
    chk({tag, "/wr"},   32'(fifo_wr),   32'(|e_ack));
    chk({tag, "/data"}, 32'(fifo_data), 32'(e_data));
    chk({tag, "/busy"}, 32'(busy),      32'(e_busy));
    chk({tag, "/own"},  32'(owner),     32'(e_owner));
    chk({tag, "/err"},  32'(stall_err), 32'(e_err));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    req_data  = 32'h44332211;
    expect_cyc("rst", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] lane_val [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk);

    // 1: single requester, two back-to-back bursts with one bubble
    do_reset();
    req = 4'b0001;
    expect_cyc("t1.grant", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      req_data[7:0] = 8'(8'hA0 + k);
      expect_cyc("t1.b1", 4'b0001, 8'(8'hA0 + k), 1'b1, 2'd0, 1'b0);
    end
    expect_cyc("t1.gap", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      req_data[7:0] = 8'(8'hB0 + k);
      expect_cyc("t1.b2", 4'b0001, 8'(8'hB0 + k), 1'b1, 2'd0, 1'b0);
    end
    req = 4'b0000;
    expect_cyc("t1.end", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);

    // 2: all requesting, rotation 0,1,2,3,0 with one bubble each
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      expect_cyc("t2.gap", 4'b0000, 8'h00, 1'b0, (g == 0) ? 2'd0 : 2'(order[g-1]), 1'b0);
      for (int b = 0; b < 4; b++)
        expect_cyc("t2.burst", 4'(4'b0001 << order[g]), lane_val[order[g]], 1'b1, 2'(order[g]), 1'b0);
    end

    // 3: owner 2 drops after two words, requester 3 is next
    do_reset();
    req = 4'b0100;
    expect_cyc("t3.grant", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
    req = 4'b1100;
    expect_cyc("t3.w0", 4'b0100, 8'h33, 1'b1, 2'd2, 1'b0);
    expect_cyc("t3.w1", 4'b0100, 8'h33, 1'b1, 2'd2, 1'b0);
    req = 4'b1000;
    expect_cyc("t3.drop", 4'b0000, 8'h33, 1'b1, 2'd2, 1'b0);
    expect_cyc("t3.idle", 4'b0000, 8'h00, 1'b0, 2'd2, 1'b0);
    expect_cyc("t3.next", 4'b1000, 8'h44, 1'b1, 2'd3, 1'b0);

    // 4: short stall mid-burst keeps the remaining beats
    do_reset();
    req = 4'b0001;
    expect_cyc("t4.grant", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
    expect_cyc("t4.w0", 4'b0001, 8'h11, 1'b1, 2'd0, 1'b0);
    expect_cyc("t4.w1", 4'b0001, 8'h11, 1'b1, 2'd0, 1'b0);
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) expect_cyc("t4.stall", 4'b0000, 8'h11, 1'b1, 2'd0, 1'b0);
    fifo_full = 1'b0;
    expect_cyc("t4.w2", 4'b0001, 8'h11, 1'b1, 2'd0, 1'b0);
    expect_cyc("t4.w3", 4'b0001, 8'h11, 1'b1, 2'd0, 1'b0);
    expect_cyc("t4.idle", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);

    // 5: stall timeout on owner 1, release to requester 2
    do_reset();
    req = 4'b0110;
    expect_cyc("t5.grant", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
    fifo_full = 1'b1;
    for (int k = 0; k < 15; k++) expect_cyc("t5.stall", 4'b0000, 8'h22, 1'b1, 2'd1, 1'b0);
    expect_cyc("t5.err", 4'b0000, 8'h00, 1'b0, 2'd1, 1'b1);
    fifo_full = 1'b0;
    expect_cyc("t5.next", 4'b0100, 8'h33, 1'b1, 2'd2, 1'b0);

    // 6: asynchronous reset on beat 2
    do_reset();
    req = 4'b0001;
    expect_cyc("t6.grant", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
    expect_cyc("t6.w0", 4'b0001, 8'h11, 1'b1, 2'd0, 1'b0);
    expect_cyc("t6.w1", 4'b0001, 8'h11, 1'b1, 2'd0, 1'b0);
    #1;
    chk("t6.pre/ack", 32'(ack), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6.rst/ack",  32'(ack),       32'h0);
    chk("t6.rst/wr",   32'(fifo_wr),   32'h0);
    chk("t6.rst/busy", 32'(busy),      32'h0);
    chk("t6.rst/data", 32'(fifo_data), 32'h0);
    chk("t6.rst/own",  32'(owner),     32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1001;
    expect_cyc("t6.grant2", 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
    expect_cyc("t6.first",  4'b0001, 8'h11, 1'b1, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
